// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and shared-memory buses around mem_arbiter.
// The arbiter takes the slave view; requesters plus memory model take the master view.
interface mem_arbiter_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 i_req;
    logic [BIT_WIDTH-1:0] i_addr;
    logic [BIT_WIDTH-1:0] i_rdata;
    logic                 i_ack;

    logic                 d_req;
    logic                 d_we;
    logic [1:0]           d_size;
    logic [BIT_WIDTH-1:0] d_addr;
    logic [BIT_WIDTH-1:0] d_wdata;
    logic [BIT_WIDTH-1:0] d_rdata;
    logic                 d_ack;

    logic                 m_req;
    logic                 m_we;
    logic [1:0]           m_size;
    logic [BIT_WIDTH-1:0] m_addr;
    logic [BIT_WIDTH-1:0] m_wdata;
    logic [BIT_WIDTH-1:0] m_rdata;
    logic                 m_ack_n;

    logic                 grant_d;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ack_n,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_size, m_addr, m_wdata, grant_d
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ack_n,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_size, m_addr, m_wdata, grant_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch I, data D) arbiter onto one shared memory port.
// D has priority, but I is forced through after STARVE_LIMIT consecutive D wins.
module mem_arbiter #(
    parameter int BIT_WIDTH    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [1:0]           state;
    logic [CNT_W-1:0]     starve_cnt;
    logic                 grant_d_q;
    logic                 m_we_q;
    logic [1:0]           m_size_q;
    logic [BIT_WIDTH-1:0] m_addr_q;
    logic [BIT_WIDTH-1:0] m_wdata_q;
    logic [BIT_WIDTH-1:0] i_rdata_q;
    logic [BIT_WIDTH-1:0] d_rdata_q;
    logic                 pick_d;

    always_comb begin
        pick_d = bus.d_req && !(bus.i_req && (starve_cnt == CNT_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            grant_d_q  <= 1'b0;
            m_we_q     <= 1'b0;
            m_size_q   <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        grant_d_q <= pick_d;
                        if (pick_d) begin
                            m_we_q    <= bus.d_we;
                            m_size_q  <= bus.d_size;
                            m_addr_q  <= bus.d_addr;
                            m_wdata_q <= bus.d_wdata;
                        end else begin
                            m_we_q    <= 1'b0;
                            m_size_q  <= '0;
                            m_addr_q  <= bus.i_addr;
                            m_wdata_q <= '0;
                        end
                        // Counts only D wins that made a waiting I lose; saturates.
                        if (pick_d && bus.i_req) begin
                            if (starve_cnt != CNT_MAX) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.m_ack_n) begin
                        if (!grant_d_q) begin
                            i_rdata_q <= bus.m_rdata;
                        end else if (!m_we_q) begin
                            d_rdata_q <= bus.m_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_req   = (state == BUSY);
    assign bus.m_we    = m_we_q;
    assign bus.m_size  = m_size_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ack   = (state == RESP) && !grant_d_q;
    assign bus.d_ack   = (state == RESP) && grant_d_q;
    assign bus.grant_d = grant_d_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// request/latency traffic, checked against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int BW    = 32;
    localparam int LIMIT = 4;

    logic clk;
    logic rst;

    mem_arbiter_if #(.BIT_WIDTH(BW)) bus ();

    mem_arbiter #(
        .BIT_WIDTH    (BW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: consecutive D wins against a waiting I, and last read data.
    int          streak = 0;
    logic [31:0] exp_i_rdata = '0;
    logic [31:0] exp_d_rdata = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_req"},   32'(bus.m_req),   32'd0);
        check({tag, "_m_we"},    32'(bus.m_we),    32'd0);
        check({tag, "_m_size"},  32'(bus.m_size),  32'd0);
        check({tag, "_m_addr"},  bus.m_addr,       32'd0);
        check({tag, "_m_wdata"}, bus.m_wdata,      32'd0);
        check({tag, "_acks"},    32'({bus.i_ack, bus.d_ack}), 32'd0);
        check({tag, "_i_rdata"}, bus.i_rdata,      32'd0);
        check({tag, "_d_rdata"}, bus.d_rdata,      32'd0);
        check({tag, "_grant_d"}, 32'(bus.grant_d), 32'd0);
    endtask

    task automatic scramble_attrs();
        bus.i_addr  = $urandom;
        bus.d_addr  = $urandom;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_size  = 2'($urandom_range(0, 3));
        bus.d_wdata = $urandom;
    endtask

    // Entered #1 after an edge with the arbiter idle and at least one request up.
    // want: -1 = no fixed expectation, 0 = I must win, 1 = D must win.
    task automatic do_round(input int lat, input logic [31:0] rdata, input bit mutate, input int want);
        bit          win_d;
        bit          ewe;
        logic [1:0]  es;
        logic [31:0] ea;
        logic [31:0] ew;
        win_d = bus.d_req && !(bus.i_req && streak >= LIMIT);
        if (win_d && bus.i_req) streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
        else                    streak = 0;
        if (win_d) begin
            ea = bus.d_addr; ewe = bus.d_we; es = bus.d_size; ew = bus.d_wdata;
        end else begin
            ea = bus.i_addr; ewe = 1'b0; es = 2'b00; ew = '0;
        end
        bus.m_ack_n = 1'($urandom_range(0, 1));
        bus.m_rdata = $urandom;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            check("busy_m_req",   32'(bus.m_req),   32'd1);
            check("busy_m_addr",  bus.m_addr,       ea);
            check("busy_m_we",    32'(bus.m_we),    32'(ewe));
            check("busy_m_size",  32'(bus.m_size),  32'(es));
            check("busy_m_wdata", bus.m_wdata,      ew);
            check("busy_grant_d", 32'(bus.grant_d), 32'(win_d));
            check("busy_acks",    32'({bus.i_ack, bus.d_ack}), 32'd0);
            if (k == 1 && want >= 0) check("grant_fixed", 32'(bus.grant_d), 32'(want));
            if (mutate) scramble_attrs();
            bus.m_ack_n = (k == lat) ? 1'b0 : 1'b1;
            bus.m_rdata = (k == lat) ? rdata : $urandom;
        end
        @(posedge clk); #1;
        bus.m_ack_n = 1'b1;
        bus.m_rdata = $urandom;
        if (!win_d)     exp_i_rdata = rdata;
        else if (!ewe)  exp_d_rdata = rdata;
        check("resp_i_ack",   32'(bus.i_ack), 32'(!win_d));
        check("resp_d_ack",   32'(bus.d_ack), 32'(win_d));
        check("resp_m_req",   32'(bus.m_req), 32'd0);
        check("resp_i_rdata", bus.i_rdata,    exp_i_rdata);
        check("resp_d_rdata", bus.d_rdata,    exp_d_rdata);
        if (win_d) bus.d_req = 1'b0;
        else       bus.i_req = 1'b0;
        @(posedge clk); #1;
        check("idle_acks",    32'({bus.i_ack, bus.d_ack}), 32'd0);
        check("idle_m_req",   32'(bus.m_req),   32'd0);
        check("idle_grant_d", 32'(bus.grant_d), 32'(win_d));
        check("idle_i_rdata", bus.i_rdata,      exp_i_rdata);
        check("idle_d_rdata", bus.d_rdata,      exp_d_rdata);
    endtask

    task automatic idle_cycle(input bit ack_n);
        bus.m_ack_n = ack_n;
        @(posedge clk); #1;
        bus.m_ack_n = 1'b1;
        check("noreq_m_req",  32'(bus.m_req), 32'd0);
        check("noreq_acks",   32'({bus.i_ack, bus.d_ack}), 32'd0);
        check("noreq_i_data", bus.i_rdata, exp_i_rdata);
        check("noreq_d_data", bus.d_rdata, exp_d_rdata);
    endtask

    task automatic raise_d(input bit we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size; bus.d_addr = addr; bus.d_wdata = wdata;
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_size  = 2'b00;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_rdata = '0;
        bus.m_ack_n = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single fetch, zero wait states.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0010;
        do_round(1, 32'h0000_0013, 1'b0, 0);
        check("fetch_word", bus.i_rdata, 32'h0000_0013);

        // Simultaneous requests: D first, then I.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0100;
        raise_d(1'b0, 2'b00, 32'h0800_0004, 32'h5555_5555);
        do_round(3, 32'hCAFE_0001, 1'b0, 1);
        do_round(2, 32'h1234_5678, 1'b0, 0);

        // Byte store with attributes wiggling during BUSY; d_rdata must survive.
        raise_d(1'b1, 2'b10, 32'hF000_0000, 32'h0000_0041);
        do_round(3, 32'hDEAD_BEEF, 1'b1, 1);
        check("store_keeps_d_rdata", bus.d_rdata, 32'hCAFE_0001);

        // Starvation: D continuously requesting, I waiting.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0200;
        raise_d(1'b0, 2'b01, 32'h0000_0400, '0);
        for (int n = 0; n < 5; n++) begin
            do_round(1 + n % 2, $urandom, 1'b0, (n < 4) ? 1 : 0);
            if (!bus.d_req) raise_d(1'b0, 2'b01, 32'h0000_0400 + 32'(n), '0);
        end
        bus.i_req = 1'b1;
        do_round(1, $urandom, 1'b0, 1);
        while (bus.i_req || bus.d_req) do_round(1, $urandom, 1'b0, -1);

        // Reset while BUSY abandons the transfer.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0300;
        raise_d(1'b0, 2'b00, 32'h0000_0500, '0);
        @(posedge clk); #1;
        check("pre_rst_m_req", 32'(bus.m_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("busy_rst");
        bus.m_ack_n = 1'b0;
        @(posedge clk); #1;
        check("rst_held_acks", 32'({bus.i_ack, bus.d_ack}), 32'd0);
        bus.m_ack_n = 1'b1;
        rst = 1'b0;
        streak = 0; exp_i_rdata = '0; exp_d_rdata = '0;
        do_round(2, 32'h0BAD_F00D, 1'b0, 1);
        while (bus.i_req || bus.d_req) do_round(1, $urandom, 1'b0, -1);

        // Stray memory acknowledge while idle.
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        for (int r = 0; r < 150; r++) begin
            if (!bus.i_req && $urandom_range(0, 1) == 1) begin
                bus.i_req = 1'b1; bus.i_addr = $urandom;
            end
            if (!bus.d_req && $urandom_range(0, 1) == 1) begin
                raise_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            end
            if (!bus.i_req && !bus.d_req) idle_cycle(1'($urandom_range(0, 1)));
            else do_round($urandom_range(1, 4), $urandom, 1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, meaning address/data width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive D grants while i_req is pending.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_req  input  1  fetch request; held high until i_ack.
REQ-006 SHALL have port i_addr  input  BIT_WIDTH  fetch address.
REQ-007 SHALL have port i_rdata  output  BIT_WIDTH  fetched instruction word.
REQ-008 SHALL have port i_ack  output  1  one-cycle completion pulse for fetch.
REQ-009 SHALL have port d_req  input  1  data request; held high until d_ack.
REQ-010 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port d_size  input  2  00 word, 01 half, 1x byte.
REQ-012 SHALL have port d_addr  input  BIT_WIDTH  data address.
REQ-013 SHALL have port d_wdata  input  BIT_WIDTH  store data.
REQ-014 SHALL have port d_rdata  output  BIT_WIDTH  load data.
REQ-015 SHALL have port d_ack  output  1  one-cycle completion pulse for data.
REQ-016 SHALL have ports m_req  output  1  and m_we  output  1  shared-memory request and write enable.
REQ-017 SHALL have ports m_size  output  2,  m_addr  output  BIT_WIDTH,  m_wdata  output  BIT_WIDTH  shared-memory attributes.
REQ-018 SHALL have ports m_rdata  input  BIT_WIDTH  and m_ack_n  input  1  memory read data and active-low acknowledge.
REQ-019 SHALL have port grant_d  output  1  high while the current or last grant is D.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-021 SHALL, in IDLE with any request high, register the winner's attributes and move to BUSY on the next edge.
REQ-022 SHALL grant D when only d_req is high, and I when only i_req is high.
REQ-023 SHALL, when both requests are high, grant D unless starve_cnt == STARVE_LIMIT, in which case it SHALL grant I.
REQ-024 SHALL increment starve_cnt on each D grant made while i_req is high, saturating at STARVE_LIMIT.
REQ-025 SHALL clear starve_cnt on any I grant, and on any arbitration in which i_req is low.
REQ-026 SHALL, in BUSY, drive m_req=1 with m_addr, m_we, m_size and m_wdata held constant at the registered values.
REQ-027 SHALL drive m_we=0 and m_wdata=0 for I grants, and m_size=00 for I grants.
REQ-028 SHALL, in BUSY, sample m_ack_n each edge; when it is sampled low, move to RESP.
REQ-029 SHALL, on that same edge, capture m_rdata into i_rdata (I grant) or into d_rdata (D load).
REQ-030 SHALL leave d_rdata unchanged on a store completion.
REQ-031 SHALL, in RESP, pulse i_ack or d_ack (matching the grant) for exactly one cycle, drive m_req=0, and ignore all requests.
REQ-032 SHALL always move from RESP to IDLE.
REQ-033 SHALL have a minimum latency from request high in IDLE to the ack cycle of 2 cycles (IDLE, BUSY with m_ack_n low, RESP).
REQ-034 SHALL have no BUSY timeout; BUSY persists while m_ack_n stays high.
REQ-035 SHALL ignore m_ack_n outside BUSY.
REQ-036 SHALL hold i_rdata and d_rdata stable between completions.
REQ-037 SHALL never assert i_ack and d_ack in the same cycle.
REQ-038 SHALL not act on a change to requester attributes during BUSY; the registered values govern.

Reset
REQ-039 SHALL, while rst is high, asynchronously force state=IDLE, m_req=0, m_we=0, m_size=00, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, grant_d=0, starve_cnt=0.
REQ-040 SHALL, on reset during BUSY, abandon the transaction with no ack, and SHALL start the first arbitration on the first edge after rst falls.

Verification
REQ-041 SHALL be verified by: i_req alone, i_addr=0x0000_0010, m_ack_n low in the first BUSY cycle, m_rdata=0x0000_0013 -> m_req high 1 cycle, i_ack on cycle 3, i_rdata=0x0000_0013.
REQ-042 SHALL be verified by: i_req and d_req both high, D load at 0x0800_0004, memory latency 3 -> D served first with d_ack; then I served with i_ack; no overlap of acks.
REQ-043 SHALL be verified by: STARVE_LIMIT=4, d_req held high continuously with i_req high -> exactly 4 D grants, then 1 I grant, then starve_cnt=0.
REQ-044 SHALL be verified by: D store to 0xF000_0000, d_size=10, d_wdata=0x41 -> m_we=1, m_size=10, m_wdata=0x41 stable until ack; d_rdata unchanged.
REQ-045 SHALL be verified by: rst pulsed high during BUSY -> m_req low immediately, no ack issued, all outputs at reset values, new grant after release.
REQ-046 SHALL be verified by: m_ack_n pulsed low while in IDLE with no requests -> no state change, no ack.
